// File: rtl/bsg_test_node_client_gen.sv
// Ring test-node client: filters ring packets by destination ID into the core, tags core payloads onto the ring.
// Optional statistics counters are built only when BSG_TEST_NODE_CLIENT_STATS_EN is defined.

module bsg_test_node_client_fifo #(
    parameter int width_p = 64,
    parameter int els_p   = 4
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               enq_i,
    input  logic [width_p-1:0] data_i,
    input  logic               deq_i,
    output logic [width_p-1:0] data_o,
    output logic               full_o,
    output logic               empty_o
);

    localparam int addr_w = $clog2(els_p);
    localparam logic [addr_w:0] ptr_one = (addr_w+1)'(1);

    // Extra MSB on each pointer flips on wrap, so equal addresses mean full or empty depending on it
    logic [addr_w:0]      wr_ptr;
    logic [addr_w:0]      rd_ptr;
    logic [width_p-1:0]   mem [els_p];
    logic                 push;
    logic                 pop;

    assign empty_o = (wr_ptr == rd_ptr);
    assign full_o  = (wr_ptr[addr_w] != rd_ptr[addr_w]) &&
                     (wr_ptr[addr_w-1:0] == rd_ptr[addr_w-1:0]);
    assign push    = enq_i & ~full_o;
    assign pop     = deq_i & ~empty_o;
    assign data_o  = mem[rd_ptr[addr_w-1:0]];

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + ptr_one;
            if (pop)  rd_ptr <= rd_ptr + ptr_one;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr[addr_w-1:0]] <= data_i;
    end

endmodule

module bsg_test_node_client_gen #(
    parameter int ring_width_p    = 80,
    parameter int payload_width_p = 64,
    parameter int id_width_p      = 4,
    parameter int client_id_p     = 0,
    parameter int fifo_els_p      = 4
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       en_i,
    input  logic                       v_i,
    input  logic [ring_width_p-1:0]    data_i,
    output logic                       ready_o,
    output logic                       v_o,
    output logic [ring_width_p-1:0]    data_o,
    input  logic                       yumi_i,
    output logic                       core_v_o,
    output logic [payload_width_p-1:0] core_data_o,
    input  logic                       core_ready_i,
    input  logic                       core_v_i,
    input  logic [payload_width_p-1:0] core_data_i,
    output logic                       core_ready_o,
    output logic [15:0]                rx_count_o,
    output logic [15:0]                tx_count_o,
    output logic [15:0]                drop_count_o
);

    if (ring_width_p < id_width_p + payload_width_p) begin : g_width_check
        $error("ring_width_p must hold id_width_p + payload_width_p bits");
    end

    localparam logic [id_width_p-1:0] my_id = id_width_p'(client_id_p);

    logic [id_width_p-1:0]      dest;
    logic                       accept;
    logic                       match;
    logic                       in_enq;
    logic                       in_deq;
    logic                       in_full;
    logic                       in_empty;
    logic                       out_enq;
    logic                       out_deq;
    logic                       out_full;
    logic                       out_empty;
    logic [payload_width_p-1:0] out_head;
    logic                       data_unused;

    // Pad bits between the ID and payload are ignored on receive
    assign data_unused = ^data_i;
    assign dest        = data_i[ring_width_p-1 -: id_width_p];
    assign match       = (dest == my_id) || (dest == {id_width_p{1'b1}});
    assign ready_o     = ~in_full;
    assign accept      = v_i & ready_o;
    assign in_enq      = accept & match;
    assign core_v_o    = en_i & ~in_empty;
    assign in_deq      = core_v_o & core_ready_i;

    assign core_ready_o = ~out_full;
    assign out_enq      = core_v_i & core_ready_o;
    assign v_o          = ~out_empty;
    assign out_deq      = yumi_i & v_o;

    bsg_test_node_client_fifo #(
        .width_p (payload_width_p),
        .els_p   (fifo_els_p)
    ) in_fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .enq_i     (in_enq),
        .data_i    (data_i[payload_width_p-1:0]),
        .deq_i     (in_deq),
        .data_o    (core_data_o),
        .full_o    (in_full),
        .empty_o   (in_empty)
    );

    bsg_test_node_client_fifo #(
        .width_p (payload_width_p),
        .els_p   (fifo_els_p)
    ) out_fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .enq_i     (out_enq),
        .data_i    (core_data_i),
        .deq_i     (out_deq),
        .data_o    (out_head),
        .full_o    (out_full),
        .empty_o   (out_empty)
    );

    always_comb begin
        data_o = '0;
        data_o[ring_width_p-1 -: id_width_p] = my_id;
        data_o[payload_width_p-1:0]          = out_head;
    end

`ifdef BSG_TEST_NODE_CLIENT_STATS_EN
    logic [15:0] rx_count;
    logic [15:0] tx_count;
    logic [15:0] drop_count;

    // Counters stick at all-ones instead of wrapping
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rx_count   <= '0;
            tx_count   <= '0;
            drop_count <= '0;
        end else begin
            if (in_enq && rx_count != 16'hFFFF)              rx_count   <= rx_count + 16'd1;
            if (out_deq && tx_count != 16'hFFFF)             tx_count   <= tx_count + 16'd1;
            if (accept && !match && drop_count != 16'hFFFF)  drop_count <= drop_count + 16'd1;
        end
    end

    assign rx_count_o   = rx_count;
    assign tx_count_o   = tx_count;
    assign drop_count_o = drop_count;
`else
    assign rx_count_o   = '0;
    assign tx_count_o   = '0;
    assign drop_count_o = '0;
`endif

endmodule

// File: tb/tb_bsg_test_node_client_gen.sv
// Self-checking bench for bsg_test_node_client_gen: queue-based reference model, per-cycle compare, directed and random traffic.
module tb_bsg_test_node_client_gen;

    localparam int FIFO_ELS = 4;
`ifdef BSG_TEST_NODE_CLIENT_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        en_i;
    logic        v_i;
    logic [79:0] data_i;
    logic        ready_o;
    logic        v_o;
    logic [79:0] data_o;
    logic        yumi_i;
    logic        core_v_o;
    logic [63:0] core_data_o;
    logic        core_ready_i;
    logic        core_v_i;
    logic [63:0] core_data_i;
    logic        core_ready_o;
    logic [15:0] rx_count;
    logic [15:0] tx_count;
    logic [15:0] drop_count;

    int assert_count = 0;
    int fail_count   = 0;
    bit check_en     = 1'b0;

    logic [63:0] in_q[$];
    logic [63:0] out_q[$];
    int rx_m = 0;
    int tx_m = 0;
    int drop_m = 0;
    bit m_acc, m_keep, m_pop_in, m_push_out, m_pop_out;

    always #5 clk = ~clk;

    bsg_test_node_client_gen #(
        .ring_width_p    (80),
        .payload_width_p (64),
        .id_width_p      (4),
        .client_id_p     (3),
        .fifo_els_p      (FIFO_ELS)
    ) dut (
        .clk_i        (clk),
        .reset_n_i    (reset_n),
        .en_i         (en_i),
        .v_i          (v_i),
        .data_i       (data_i),
        .ready_o      (ready_o),
        .v_o          (v_o),
        .data_o       (data_o),
        .yumi_i       (yumi_i),
        .core_v_o     (core_v_o),
        .core_data_o  (core_data_o),
        .core_ready_i (core_ready_i),
        .core_v_i     (core_v_i),
        .core_data_i  (core_data_i),
        .core_ready_o (core_ready_o),
        .rx_count_o   (rx_count),
        .tx_count_o   (tx_count),
        .drop_count_o (drop_count)
    );

    function automatic logic [79:0] pkt(input logic [3:0] dest, input logic [63:0] payload);
        return {dest, 12'h0, payload};
    endfunction

    task automatic checkOutput(input string name, input logic [79:0] actual, input logic [79:0] expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [79:0] d, input logic en, input logic cr,
                                 input logic cv, input logic [63:0] cd, input logic y);
        @(posedge clk);
        #1;
        v_i = v; data_i = d; en_i = en; core_ready_i = cr;
        core_v_i = cv; core_data_i = cd; yumi_i = y;
        @(negedge clk);
    endtask

    // Reference model: two payload queues plus saturating event tallies
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_q.delete();
            out_q.delete();
            rx_m = 0;
            tx_m = 0;
            drop_m = 0;
        end else begin
            m_acc      = v_i && (in_q.size() < FIFO_ELS);
            m_keep     = m_acc && (data_i[79:76] == 4'h3 || data_i[79:76] == 4'hF);
            m_pop_in   = en_i && core_ready_i && (in_q.size() > 0);
            m_push_out = core_v_i && (out_q.size() < FIFO_ELS);
            m_pop_out  = yumi_i && (out_q.size() > 0);
            if (m_pop_in)   void'(in_q.pop_front());
            if (m_keep)     in_q.push_back(data_i[63:0]);
            if (m_pop_out)  void'(out_q.pop_front());
            if (m_push_out) out_q.push_back(core_data_i);
            if (m_keep && rx_m < 65535) rx_m++;
            if (m_pop_out && tx_m < 65535) tx_m++;
            if (m_acc && !m_keep && drop_m < 65535) drop_m++;
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("ready_o", 80'(ready_o), 80'(in_q.size() < FIFO_ELS));
            checkOutput("core_v_o", 80'(core_v_o), 80'(en_i && in_q.size() > 0));
            if (en_i && in_q.size() > 0) checkOutput("core_data_o", 80'(core_data_o), 80'(in_q[0]));
            checkOutput("core_ready_o", 80'(core_ready_o), 80'(out_q.size() < FIFO_ELS));
            checkOutput("v_o", 80'(v_o), 80'(out_q.size() > 0));
            if (out_q.size() > 0) checkOutput("data_o", data_o, {4'h3, 12'h0, out_q[0]});
            checkOutput("rx_count", 80'(rx_count), STATS ? 80'(rx_m) : 80'd0);
            checkOutput("tx_count", 80'(tx_count), STATS ? 80'(tx_m) : 80'd0);
            checkOutput("drop_count", 80'(drop_count), STATS ? 80'(drop_m) : 80'd0);
        end
    end

    initial begin
        logic [3:0] dest;
        reset_n = 1'b0;
        v_i = 1'b0; data_i = '0; en_i = 1'b1; core_ready_i = 1'b0;
        core_v_i = 1'b0; core_data_i = '0; yumi_i = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_ready_o", 80'(ready_o), 80'd1);
        checkOutput("reset_core_ready_o", 80'(core_ready_o), 80'd1);
        checkOutput("reset_v_o", 80'(v_o), 80'd0);
        checkOutput("reset_core_v_o", 80'(core_v_o), 80'd0);
        checkOutput("reset_rx_count", 80'(rx_count), 80'd0);

        // Match path, first acceptance on the first edge after release
        reset_n = 1'b1;
        check_en = 1'b1;
        v_i = 1'b1; data_i = pkt(4'h3, 64'h1234); core_ready_i = 1'b1;
        applyStimulus(0, '0, 1, 1, 0, '0, 0);
        checkOutput("match_core_v", 80'(core_v_o), 80'd1);
        checkOutput("match_core_data", 80'(core_data_o), 80'h1234);
        checkOutput("match_rx", 80'(rx_count), STATS ? 80'd1 : 80'd0);
        checkOutput("model_in_depth", 80'(in_q.size()), 80'd1);
        applyStimulus(0, '0, 1, 1, 0, '0, 0);
        checkOutput("match_drained", 80'(core_v_o), 80'd0);

        // Filtering and broadcast, no bypass
        applyStimulus(1, pkt(4'h5, 64'h55), 1, 0, 0, '0, 0);
        applyStimulus(1, pkt(4'hF, 64'h66), 1, 0, 0, '0, 0);
        checkOutput("filter_drop", 80'(drop_count), STATS ? 80'd1 : 80'd0);
        checkOutput("no_bypass", 80'(core_v_o), 80'd0);
        applyStimulus(0, '0, 1, 0, 0, '0, 0);
        checkOutput("bcast_core_v", 80'(core_v_o), 80'd1);
        checkOutput("bcast_data", 80'(core_data_o), 80'h66);
        checkOutput("bcast_rx", 80'(rx_count), STATS ? 80'd2 : 80'd0);
        applyStimulus(0, '0, 1, 1, 0, '0, 0);
        applyStimulus(0, '0, 1, 1, 0, '0, 0);
        checkOutput("bcast_drained", 80'(core_v_o), 80'd0);

        // Fill with en_i low, then drain in order while the fifth waits
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, pkt(4'h3, 64'(100 + i)), 0, 1, 0, '0, 0);
            checkOutput("fill_ready", 80'(ready_o), (i < 4) ? 80'd1 : 80'd0);
        end
        checkOutput("model_full_depth", 80'(in_q.size()), 80'd4);
        applyStimulus(1, pkt(4'h3, 64'd104), 0, 1, 0, '0, 0);
        checkOutput("full_core_v_en_low", 80'(core_v_o), 80'd0);
        applyStimulus(1, pkt(4'h3, 64'd104), 1, 1, 0, '0, 0);
        checkOutput("full_blocks_enq", 80'(ready_o), 80'd0);
        checkOutput("drain_0", 80'(core_data_o), 80'd100);
        applyStimulus(1, pkt(4'h3, 64'd104), 1, 1, 0, '0, 0);
        checkOutput("ready_again", 80'(ready_o), 80'd1);
        checkOutput("drain_1", 80'(core_data_o), 80'd101);
        for (int i = 2; i < 5; i++) begin
            applyStimulus(0, '0, 1, 1, 0, '0, 0);
            checkOutput("drain_n", 80'(core_data_o), 80'(100 + i));
        end
        applyStimulus(0, '0, 1, 1, 0, '0, 0);
        checkOutput("drain_empty", 80'(core_v_o), 80'd0);
        checkOutput("fill_rx", 80'(rx_count), STATS ? 80'd7 : 80'd0);

        // Output tagging held under backpressure
        applyStimulus(0, '0, 1, 1, 1, 64'hABCD, 0);
        checkOutput("tag_not_yet", 80'(v_o), 80'd0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, '0, 1, 1, 0, '0, 0);
            checkOutput("tag_v_o", 80'(v_o), 80'd1);
            checkOutput("tag_data", data_o, {4'h3, 12'h0, 64'hABCD});
        end
        applyStimulus(0, '0, 1, 1, 0, '0, 1);
        applyStimulus(0, '0, 1, 1, 0, '0, 0);
        checkOutput("tag_popped", 80'(v_o), 80'd0);
        checkOutput("tag_tx", 80'(tx_count), STATS ? 80'd1 : 80'd0);
        applyStimulus(0, '0, 1, 1, 0, '0, 1);
        applyStimulus(0, '0, 1, 1, 0, '0, 0);
        checkOutput("illegal_yumi_tx", 80'(tx_count), STATS ? 80'd1 : 80'd0);

        // Asynchronous reset with both FIFOs holding two entries
        applyStimulus(1, pkt(4'h3, 64'h77), 0, 0, 1, 64'h88, 0);
        applyStimulus(1, pkt(4'h3, 64'h78), 0, 0, 1, 64'h89, 0);
        applyStimulus(0, '0, 1, 0, 0, '0, 0);
        checkOutput("prereset_core_v", 80'(core_v_o), 80'd1);
        checkOutput("prereset_v_o", 80'(v_o), 80'd1);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("async_v_o", 80'(v_o), 80'd0);
        checkOutput("async_core_v", 80'(core_v_o), 80'd0);
        checkOutput("async_ready", 80'(ready_o), 80'd1);
        checkOutput("async_rx", 80'(rx_count), 80'd0);
        checkOutput("async_tx", 80'(tx_count), 80'd0);
        checkOutput("async_drop", 80'(drop_count), 80'd0);
        #1 reset_n = 1'b1;
        applyStimulus(1, pkt(4'h3, 64'h99), 1, 1, 0, '0, 0);
        checkOutput("post_reset_empty", 80'(core_v_o), 80'd0);
        applyStimulus(0, '0, 1, 1, 0, '0, 0);
        checkOutput("post_reset_data", 80'(core_data_o), 80'h99);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 3))
                0: dest = 4'h3;
                1: dest = 4'hF;
                2: dest = 4'($urandom);
                default: dest = 4'h5;
            endcase
            applyStimulus(1'($urandom), {dest, 12'($urandom), $urandom, $urandom},
                          1'($urandom), 1'($urandom), 1'($urandom), {$urandom, $urandom}, 1'($urandom));
        end

        // Long stream across many pointer wraps, saturating rx
        for (int i = 0; i < 70000; i++) begin
            applyStimulus(1, pkt(4'h3, 64'(i)), 1, 1, 0, '0, 1);
        end
        checkOutput("rx_saturated", 80'(rx_count), STATS ? 80'hFFFF : 80'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule

// File: doc/bsg_test_node_client_gen.md
BSG_TEST_NODE_CLIENT_GEN -- requirements
Module: bsg_test_node_client_gen

Interface
REQ-001 Parameter ring_width_p, default 80: ring packet width in bits.
REQ-002 Parameter payload_width_p, default 64: core payload width in bits.
REQ-003 Parameter id_width_p, default 4: client ID field width in bits.
REQ-004 Parameter client_id_p, default 0: this node's ID.
REQ-005 Parameter fifo_els_p, default 4: depth of each FIFO; a power of two, at least 2.
REQ-006 The port clk_i, input, width 1, SHALL be the single clock; all state changes on its rising edge.
REQ-007 The port reset_n_i, input, width 1, SHALL be the reset; it is asynchronous and active-low.
REQ-008 The port en_i, input, width 1, SHALL be the enable that gates input-FIFO dequeue to the core.
REQ-009 The ring input port SHALL be v_i (in, 1), data_i (in, ring_width_p) and ready_o (out, 1), using ready/valid.
REQ-010 The ring output port SHALL be v_o (out, 1), data_o (out, ring_width_p) and yumi_i (in, 1), using valid/yumi.
REQ-011 The core-bound port SHALL be core_v_o (out, 1), core_data_o (out, payload_width_p) and core_ready_i (in, 1).
REQ-012 The core-sourced port SHALL be core_v_i (in, 1), core_data_i (in, payload_width_p) and core_ready_o (out, 1).
REQ-013 The statistics outputs SHALL be rx_count_o, tx_count_o and drop_count_o, each an output 16 bits wide.

Function
REQ-014 Packet format: dest ID = data_i[ring_width_p-1 -: id_width_p]; payload = data_i[payload_width_p-1:0]; elaboration SHALL fail if ring_width_p < id_width_p + payload_width_p.
REQ-015 ready_o SHALL equal "input FIFO not full"; a packet is accepted when v_i & ready_o.
REQ-016 An accepted packet SHALL be enqueued only if dest ID == client_id_p or dest ID == all-ones (broadcast); otherwise it is consumed and discarded.
REQ-017 core_v_o SHALL equal en_i & "input FIFO not empty", and core_data_o SHALL be the head payload.
REQ-018 A dequeue SHALL occur when core_v_o & core_ready_i.
REQ-019 A payload accepted in cycle N SHALL appear on core_v_o no earlier than cycle N+1; there is no combinational bypass.
REQ-020 core_ready_o SHALL equal "output FIFO not full"; a payload is accepted when core_v_i & core_ready_o.
REQ-021 data_o SHALL be {client_id_p, zero pad, payload}; v_o SHALL equal "output FIFO not empty"; yumi_i pops; yumi_i when v_o is low is illegal and SHALL be ignored.
REQ-022 A simultaneous enqueue and dequeue on a non-full, non-empty FIFO SHALL leave occupancy unchanged.
REQ-023 When a FIFO is full, the full flag SHALL block enqueue even if a dequeue occurs in the same cycle.
REQ-024 Read and write pointers SHALL be log2(fifo_els_p) bits plus a wrap bit, so full and empty are distinguished at wrap-around.
REQ-025 When en_i is low, the input FIFO SHALL continue to accept packets until full, and the output FIFO SHALL continue to drain.
REQ-026 rx_count_o SHALL count input-FIFO enqueues, tx_count_o SHALL count output pops, and drop_count_o SHALL count discarded packets.
REQ-027 All three counters SHALL saturate at 16'hFFFF.

Reset
REQ-028 While reset_n_i is low, both FIFOs SHALL be empty and all counters zero, giving ready_o=1, core_ready_o=1, v_o=0, core_v_o=0.
REQ-029 Assertion of reset_n_i mid-transfer SHALL discard all buffered packets immediately, with no clock edge needed.
REQ-030 Deassertion of reset_n_i SHALL be treated as synchronous to clk_i, and the first acceptance SHALL be possible on the first rising edge after deassertion.

Configuration
REQ-031 When macro BSG_TEST_NODE_CLIENT_STATS_EN is defined, the counters of REQ-026 and REQ-027 SHALL be implemented.
REQ-032 When BSG_TEST_NODE_CLIENT_STATS_EN is undefined, no counter registers SHALL exist, rx_count_o, tx_count_o and drop_count_o SHALL be tied to 0, and all other behaviour SHALL be unchanged.

Verification
REQ-033 Match path: client_id_p=3; send dest=3, payload=64'h1234 with core_ready_i=1 -> core_v_o high one cycle later with 64'h1234; with stats enabled, rx_count_o=1.
REQ-034 Filtering: send dest=5, then dest=4'hF -> first discarded with drop_count_o=1; second delivered as broadcast.
REQ-035 Full/backpressure: en_i=0; send 5 matching packets with fifo_els_p=4 -> ready_o low after 4 packets; set en_i=1 -> 4 payloads in order, then the 5th is accepted.
REQ-036 Output tagging: client_id_p=3, core_data_i=64'hABCD, yumi_i held low 3 cycles -> data_o = {4'h3, 12'h0, 64'hABCD} stable with v_o high until yumi_i; tx_count_o=1 after the pop.
REQ-037 Reset mid-operation: fill both FIFOs with 2 entries, pulse reset_n_i low between clock edges -> v_o, core_v_o and counters go to 0 immediately; no stale data after release.
REQ-038 Wrap-around and saturation: stream 70000 matching packets with continuous dequeue -> order preserved across pointer wrap; rx_count_o holds at 16'hFFFF.
